regfile_scoreboard: RTL and testbench

//  Parametrised 2-read/1-write integer register file with writeback-to-read bypass and a per-register

---
 rtl/regfile_scoreboard_pkg.sv | 22 ++
 rtl/regfile_scoreboard_scoreboard_bits.sv | 84 ++++++++
 rtl/regfile_scoreboard.sv | 134 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard_pkg
//   Shared defaults and helpers for the register file / scoreboard slice.
//   Contents:
//     XLEN_DEFAULT      default data width of one register
//     NREG_DEFAULT      default number of architectural registers
//     ZERO_REG_DEFAULT  default for the hard-wired-zero register 0 behaviour
//     addr_width()      address width derived from the register count
// ---------------------------------------------------------------------------
package regfile_scoreboard_pkg;

  localparam int XLEN_DEFAULT     = 32;
  localparam int NREG_DEFAULT     = 32;
  localparam int ZERO_REG_DEFAULT = 1;

  // Register counts are powers of two >= 2. The lower clamp keeps the
  // address at least one bit wide even for the smallest legal file.
  function automatic int addr_width(input int nreg);
    return (nreg <= 2) ? 1 : $clog2(nreg);
  endfunction

endpackage : regfile_scoreboard_pkg

// File: rtl/regfile_scoreboard_scoreboard_bits.sv
// ---------------------------------------------------------------------------
// scoreboard_bits
//   Per-register pending vector plus a registered count of pending entries.
//   Ports:
//     clk          clock, all state changes on the rising edge
//     rst          synchronous active-high reset, clears everything
//     flush        clears every pending bit; beats set and clear
//     set_en       mark set_addr pending (caller has already masked reg 0)
//     set_addr     register being claimed by a new producer
//     clr_en       release clr_addr (writeback)
//     clr_addr     register being written back
//     pending      current pending vector (registered)
//     pending_cnt  population count of pending (registered)
//   Priority per bit: flush > set > clear > hold. A set and a clear of the
//   same register in one cycle leaves the bit set, since the newly issued
//   instruction now owns the register.
// ---------------------------------------------------------------------------
module scoreboard_bits
  import regfile_scoreboard_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT,
  localparam int AW = addr_width(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            set_en,
  input  logic [AW-1:0]   set_addr,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_addr,
  output logic [NREG-1:0] pending,
  output logic [AW:0]     pending_cnt
);

  logic [NREG-1:0] pending_reg;
  logic [NREG-1:0] pending_next;
  logic [AW:0]     cnt_reg;
  logic [AW:0]     cnt_next;
  logic            cnt_inc;
  logic            cnt_dec;

  // Per-bit next state.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
    logic set_hit;
    logic clr_hit;
    assign set_hit = set_en && (set_addr == AW'(gi));
    assign clr_hit = clr_en && (clr_addr == AW'(gi));
    assign pending_next[gi] = flush   ? 1'b0 :
                              set_hit ? 1'b1 :
                              clr_hit ? 1'b0 :
                                        pending_reg[gi];
  end

  // Incremental count instead of a popcount tree: +1 when a clear bit gets
  // set, -1 when a set bit gets cleared. A clear that collides with a set
  // on the same register is swallowed by the set, so it never decrements.
  // Set and clear on different registers give +1 -1 = net 0.
  assign cnt_inc = set_en && !pending_reg[set_addr];
  assign cnt_dec = clr_en && pending_reg[clr_addr] &&
                   !(set_en && (set_addr == clr_addr));

  always_comb begin
    cnt_next = cnt_reg;
    if (flush) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
      cnt_reg     <= '0;
    end else begin
      pending_reg <= pending_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign pending     = pending_reg;
  assign pending_cnt = cnt_reg;

endmodule : scoreboard_bits

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   2-read / 1-write integer register file for the decode stage, with a
//   same-cycle writeback-to-read bypass and a pending bit per register so the
//   stall logic can see outstanding producers.
//   Ports:
//     clk, rst                 clock and synchronous active-high reset
//     rs1_addr/rs2_addr        read addresses
//     rs1_data/rs2_data        combinational read data, bypassed from wb
//     rs1_busy/rs2_busy        source still waiting on a producer this cycle
//     issue_valid/issue_rd     instruction issuing, claims issue_rd
//     rd_busy                  issue_rd already pending (WAW), ignores valid
//     wb_en/wb_addr/wb_data    writeback: write data and release pending
//     flush                    drop all outstanding producers, keep data
//     pending_cnt              registered count of pending registers
//   With ZERO_REG != 0, register 0 reads as zero, ignores writes and is
//   never marked pending.
// ---------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREG     = NREG_DEFAULT,
  parameter int ZERO_REG = ZERO_REG_DEFAULT,
  localparam int AW      = addr_width(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            rd_busy,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic [AW:0]     pending_cnt
);

  localparam bit ZERO_EN = (ZERO_REG != 0);

  // Register storage. Every entry is cleared on reset and both read ports
  // are asynchronous, so this maps to flops/distributed RAM, not block RAM.
  logic [XLEN-1:0] rf_reg [NREG];
  logic [NREG-1:0] wr_sel;
  logic [NREG-1:0] pending;

  logic wr_en;
  logic set_en;
  logic rs1_zero;
  logic rs2_zero;
  logic rd_zero;
  logic rs1_bypass;
  logic rs2_bypass;

  // Writes to a hard-wired zero register are dropped here; the pending
  // clear below still uses raw wb_en, which is harmless because bit 0 can
  // never become set in that configuration.
  assign wr_en = wb_en && !(ZERO_EN && (wb_addr == '0));

  for (genvar gi = 0; gi < NREG; gi++) begin : g_wr_sel
    assign wr_sel[gi] = wr_en && (wb_addr == AW'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_sel[i]) begin
          rf_reg[i] <= wb_data;
        end
      end
    end
  end

  // Address qualifiers shared by data and busy paths.
  assign rs1_zero   = ZERO_EN && (rs1_addr == '0);
  assign rs2_zero   = ZERO_EN && (rs2_addr == '0);
  assign rd_zero    = ZERO_EN && (issue_rd == '0);
  assign rs1_bypass = wb_en && (wb_addr == rs1_addr);
  assign rs2_bypass = wb_en && (wb_addr == rs2_addr);

  // Read muxes: zero register beats the bypass, bypass beats the array.
  always_comb begin
    rs1_data = rf_reg[rs1_addr];
    if (rs1_bypass) begin
      rs1_data = wb_data;
    end
    if (rs1_zero) begin
      rs1_data = '0;
    end
  end

  always_comb begin
    rs2_data = rf_reg[rs2_addr];
    if (rs2_bypass) begin
      rs2_data = wb_data;
    end
    if (rs2_zero) begin
      rs2_data = '0;
    end
  end

  // A source whose producer is writing back right now is satisfied by the
  // bypass, so it is not reported busy.
  assign rs1_busy = pending[rs1_addr] && !rs1_bypass && !rs1_zero;
  assign rs2_busy = pending[rs2_addr] && !rs2_bypass && !rs2_zero;
  assign rd_busy  = pending[issue_rd] && !rd_zero;

  assign set_en = issue_valid && !rd_zero;

  scoreboard_bits #(
    .NREG (NREG)
  ) u_scoreboard_bits (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .set_en      (set_en),
    .set_addr    (issue_rd),
    .clr_en      (wb_en),
    .clr_addr    (wb_addr),
    .pending     (pending),
    .pending_cnt (pending_cnt)
  );

endmodule : regfile_scoreboard

// File: tb/tb_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard
//   Directed stimulus with hand-computed expectations. The stimulus process
//   drives one cycle at a time and queues what the outputs must show during
//   that cycle; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_regfile_scoreboard;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  // Field mask bits for an expectation entry.
  localparam logic [5:0] M_D1  = 6'b000001;
  localparam logic [5:0] M_D2  = 6'b000010;
  localparam logic [5:0] M_B1  = 6'b000100;
  localparam logic [5:0] M_B2  = 6'b001000;
  localparam logic [5:0] M_RDB = 6'b010000;
  localparam logic [5:0] M_CNT = 6'b100000;
  localparam logic [5:0] M_ALL = 6'b111111;

  typedef struct {
    string       name;
    logic [5:0]  mask;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic        rdb;
    logic [5:0]  cnt;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            rd_busy;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic [AW:0]     pending_cnt;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  regfile_scoreboard #(
    .XLEN     (XLEN),
    .NREG     (NREG),
    .ZERO_REG (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rd_busy     (rd_busy),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .flush       (flush),
    .pending_cnt (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- monitor ----------------
  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", name, field, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("check %-22s rs1=%0d d1=0x%08h b1=%0b rs2=%0d d2=0x%08h b2=%0b rd_busy=%0b cnt=%0d",
               e.name, rs1_addr, rs1_data, rs1_busy, rs2_addr, rs2_data, rs2_busy,
               rd_busy, pending_cnt);
      if (e.mask[0]) cmp(e.name, "rs1_data", rs1_data, e.d1);
      if (e.mask[1]) cmp(e.name, "rs2_data", rs2_data, e.d2);
      if (e.mask[2]) cmp(e.name, "rs1_busy", {31'd0, rs1_busy}, {31'd0, e.b1});
      if (e.mask[3]) cmp(e.name, "rs2_busy", {31'd0, rs2_busy}, {31'd0, e.b2});
      if (e.mask[4]) cmp(e.name, "rd_busy", {31'd0, rd_busy}, {31'd0, e.rdb});
      if (e.mask[5]) cmp(e.name, "pending_cnt", {26'd0, pending_cnt}, {26'd0, e.cnt});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst         = 1'b0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    wb_en       = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    flush       = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [5:0] mask,
                            input logic [31:0] d1, input logic [31:0] d2,
                            input logic b1, input logic b2, input logic rdb,
                            input logic [5:0] cnt);
    exp_t e;
    e.name = name; e.mask = mask;
    e.d1 = d1; e.d2 = d2; e.b1 = b1; e.b2 = b2; e.rdb = rdb; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic issue_one(input logic [AW-1:0] rd);
    idle();
    issue_valid = 1'b1;
    issue_rd    = rd;
    step();
  endtask

  // Watchdog: the run is a fixed directed sequence, so this never fires
  // unless something hangs.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    rs1_addr = '0;
    rs2_addr = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // 1. Post-reset: everything reads zero, nothing busy.
    for (int a = 0; a < NREG; a++) begin
      idle();
      rs1_addr = AW'(a);
      rs2_addr = AW'(31 - a);
      issue_rd = AW'(a);
      expect_out("reset_read", M_ALL, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);
      step();
    end

    // 2. Same-cycle bypass, then value held in the array.
    idle();
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    rs1_addr = 5'd5; rs2_addr = 5'd0;
    expect_out("bypass_wb5", M_D1 | M_D2 | M_CNT, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);
    step();
    idle();
    rs1_addr = 5'd5;
    expect_out("held_x5", M_D1 | M_B1, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);
    step();

    // 3. Register 0 is hard-wired: write and issue are both ignored.
    idle();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
    issue_valid = 1'b1; issue_rd = 5'd0;
    rs1_addr = 5'd0;
    expect_out("x0_wb_issue", M_D1 | M_B1 | M_RDB | M_CNT, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);
    step();
    idle();
    rs1_addr = 5'd0; issue_rd = 5'd0;
    expect_out("x0_after", M_D1 | M_B1 | M_RDB | M_CNT, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);
    step();

    // 4. Issue x7, observe busy, then writeback clears it with bypass.
    idle();
    issue_valid = 1'b1; issue_rd = 5'd7; rs2_addr = 5'd7;
    expect_out("issue_x7", M_B2 | M_RDB | M_CNT, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);
    step();
    idle();
    rs2_addr = 5'd7; issue_rd = 5'd7;
    expect_out("x7_pending", M_D2 | M_B2 | M_RDB | M_CNT, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 6'd1);
    step();
    idle();
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h55; rs2_addr = 5'd7;
    expect_out("wb_x7", M_D2 | M_B2 | M_CNT, 32'h0, 32'h55, 1'b0, 1'b0, 1'b0, 6'd1);
    step();
    idle();
    rs2_addr = 5'd7;
    expect_out("x7_released", M_D2 | M_B2 | M_CNT, 32'h0, 32'h55, 1'b0, 1'b0, 1'b0, 6'd0);
    step();

    // 5. Issue and writeback of pending x3 in one cycle: set wins.
    issue_one(5'd3);
    idle();
    issue_valid = 1'b1; issue_rd = 5'd3;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hA5A5A5A5;
    rs1_addr = 5'd3;
    expect_out("x3_issue_and_wb", M_D1 | M_B1 | M_RDB | M_CNT, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 1'b1, 6'd1);
    step();
    idle();
    rs1_addr = 5'd3;
    expect_out("x3_still_pending", M_D1 | M_B1 | M_CNT, 32'hA5A5A5A5, 32'h0, 1'b1, 1'b0, 1'b0, 6'd1);
    step();

    // Writeback to a register nobody owns: data lands, count untouched.
    idle();
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h77;
    step();
    idle();
    rs1_addr = 5'd10;
    expect_out("wb_nonpending_x10", M_D1 | M_B1 | M_CNT, 32'h77, 32'h0, 1'b0, 1'b0, 1'b0, 6'd1);
    step();
    idle();
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
    step();
    idle();
    rs1_addr = 5'd3;
    expect_out("x3_released", M_D1 | M_B1 | M_CNT, 32'h33, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);
    step();

    // 6. Three producers, then flush with a competing issue.
    issue_one(5'd1);
    issue_one(5'd2);
    issue_one(5'd9);
    idle();
    rs1_addr = 5'd1; rs2_addr = 5'd9;
    expect_out("three_pending", M_B1 | M_B2 | M_CNT, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 6'd3);
    step();
    idle();
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd4;
    rs1_addr = 5'd4; rs2_addr = 5'd2;
    expect_out("flush_cycle", M_B1 | M_B2 | M_CNT, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 6'd3);
    step();
    idle();
    rs1_addr = 5'd4; rs2_addr = 5'd2; issue_rd = 5'd4;
    expect_out("after_flush", M_B1 | M_B2 | M_RDB | M_CNT, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);
    step();

    // Counter at its top: every non-zero register pending, re-issue holds.
    for (int r = 1; r < NREG; r++) begin
      issue_one(AW'(r));
    end
    idle();
    rs1_addr = 5'd31; rs2_addr = 5'd0;
    expect_out("all_pending", M_B1 | M_B2 | M_CNT, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 6'd31);
    step();
    issue_one(5'd5);
    idle();
    expect_out("reissue_no_wrap", M_CNT, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd31);
    step();
    idle();
    wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'h12;
    issue_valid = 1'b1; issue_rd = 5'd12;
    expect_out("full_set_clr_same", M_CNT, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd31);
    step();
    idle();
    wb_en = 1'b1; wb_addr = 5'd13; wb_data = 32'h13;
    step();
    idle();
    expect_out("full_minus_one", M_CNT, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd30);
    step();
    idle();
    flush = 1'b1;
    step();

    // Reset in the middle of activity wipes data and producers.
    issue_one(5'd6);
    idle();
    rst = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hFFFF;
    issue_valid = 1'b1; issue_rd = 5'd8;
    expect_out("pre_reset_cnt", M_CNT, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd1);
    step();
    idle();
    rs1_addr = 5'd5; rs2_addr = 5'd10; issue_rd = 5'd8;
    expect_out("post_reset_read", M_ALL, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);
    step();
    idle();
    rs1_addr = 5'd6; rs2_addr = 5'd7;
    expect_out("post_reset_busy", M_ALL, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);
    step();

    idle();
    step();
    step();

    // Every queued expectation must have been consumed by the monitor.
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_regfile_scoreboard
